// File: rtl/mux10_serializer_pkg.sv
// Shared types and constants for the 10-bit word serializer.
// SER_MSB_FIRST_EN selects MSB-first bit order (default LSB-first).
package mux10_serializer_pkg;
  localparam int WORD_W = 10;
  localparam int SEL_W  = 4;
  localparam int MUX_W  = 16;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

`ifdef SER_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_IDX  = 4'd9;
  localparam logic [SEL_W-1:0] FINAL_IDX  = 4'd0;
  localparam bit               COUNT_DOWN = 1'b1;
`else
  localparam logic [SEL_W-1:0] FIRST_IDX  = 4'd0;
  localparam logic [SEL_W-1:0] FINAL_IDX  = 4'd9;
  localparam bit               COUNT_DOWN = 1'b0;
`endif
endpackage

// File: rtl/mux10_serializer_if.sv
// Word input, mux drive/return and serial output bundle of mux10_serializer.
interface mux10_serializer_if;
  import mux10_serializer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [MUX_W-1:0]  mux_i;
  logic [SEL_W-1:0]  mux_s;
  logic              mux_y;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_data;
  logic              ser_last;

  // master: environment side (word source, external mux, bit sink)
  modport master (
    output in_valid, in_data, mux_y, ser_ready,
    input  in_ready, mux_i, mux_s, ser_valid, ser_data, ser_last
  );

  modport slave (
    input  in_valid, in_data, mux_y, ser_ready,
    output in_ready, mux_i, mux_s, ser_valid, ser_data, ser_last
  );
endinterface

// File: rtl/mux10_serializer_sel_counter.sv
// 4-bit mux select counter: load to the first index, step toward the final
// index on enable, and flag when the final index is reached.
module mux10_serializer_sel_counter
  import mux10_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [SEL_W-1:0] idx,
  output logic             is_final
);
  assign is_final = (idx == FINAL_IDX);

  // Stepping stops at the final index so the select never leaves 0..9.
  always_ff @(posedge clk) begin
    if (!rst_n)
      idx <= '0;
    else if (load)
      idx <= FIRST_IDX;
    else if (en && !is_final)
      idx <= COUNT_DOWN ? idx - SEL_W'(1) : idx + SEL_W'(1);
  end
endmodule

// File: rtl/mux10_serializer.sv
// Holds a 10-bit word on an external 10:1 mux, walks the select, and
// registers each mux output bit into a valid/ready serial stream.
// Bit order is set by SER_MSB_FIRST_EN (see package).
module mux10_serializer
  import mux10_serializer_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  mux10_serializer_if.slave bus
);
  state_t            state, state_nxt;
  logic              accept, cap, in_rdy;
  logic              is_final;
  logic [SEL_W-1:0]  idx;
  logic [WORD_W-1:0] word;
  logic              sv, sd, sl;

  mux10_serializer_sel_counter u_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .en       (cap),
    .idx      (idx),
    .is_final (is_final)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    accept    = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        accept = bus.in_valid;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        cap = !sv || bus.ser_ready;
        if (cap && is_final) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A capture overrides a consume, so a freed slot refills with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= '0;
      sv   <= 1'b0;
      sd   <= 1'b0;
      sl   <= 1'b0;
    end else begin
      if (accept) word <= bus.in_data;
      if (cap) begin
        sd <= bus.mux_y;
        sv <= 1'b1;
        sl <= is_final;
      end else if (sv && bus.ser_ready) begin
        sv <= 1'b0;
        sl <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.mux_i     = {{(MUX_W-WORD_W){1'b0}}, word};
  assign bus.mux_s     = idx;
  assign bus.ser_valid = sv;
  assign bus.ser_data  = sd;
  assign bus.ser_last  = sl;
endmodule

// File: tb/tb_mux10_serializer.sv
// Bench for mux10_serializer with a behavioural 10:1 mux closing the loop;
// expected bits are queued on each accept and popped on each serial handshake.
module tb_mux10_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux10_serializer_if bus();
  mux10_serializer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.mux_y = bus.mux_i[bus.mux_s];

  typedef struct packed { logic d; logic l; } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic s_acc, s_fire, s_vld, s_data, s_last, s_rdy, s_sready, e_ok;
  logic [3:0]  s_sel;
  logic [15:0] s_mi;
  exp_t e;

  function automatic int order(int k);
`ifdef SER_MSB_FIRST_EN
    return 9 - k;
`else
    return k;
`endif
  endfunction

  // Sample mid-cycle (handshakes seen here complete at the next rising edge),
  // update the scoreboard, then return just after that edge.
  task automatic tick();
    @(negedge clk);
    s_rdy = bus.in_ready; s_vld = bus.ser_valid; s_data = bus.ser_data;
    s_last = bus.ser_last; s_sel = bus.mux_s; s_mi = bus.mux_i; s_sready = bus.ser_ready;
    s_acc = bus.in_valid && bus.in_ready;
    s_fire = bus.ser_valid && bus.ser_ready;
    if (s_acc)
      for (int k = 0; k < 10; k++) q.push_back('{d: bus.in_data[order(k)], l: (k == 9)});
    e_ok = 1'b0;
    if (s_fire && q.size() != 0) begin e = q.pop_front(); e_ok = 1'b1; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.ser_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_cmp++; if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", s_rdy); end
    n_cmp++; if (s_vld !== 1'b0) begin n_bad++; $display("FAIL reset_ser_valid got %b want 0", s_vld); end
    n_cmp++; if (s_sel !== 4'd0) begin n_bad++; $display("FAIL reset_mux_s got %0d want 0", s_sel); end
    n_cmp++; if (s_mi !== 16'd0) begin n_bad++; $display("FAIL reset_mux_i got %h want 0", s_mi); end
    n_cmp++; if (s_last !== 1'b0 || s_data !== 1'b0) begin n_bad++; $display("FAIL reset_ser_bits got last=%b data=%b want 0/0", s_last, s_data); end
  endtask

  task automatic test_single();
    bus.ser_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 10'b10_1010_1010;
    tick();
    n_cmp++; if (s_acc !== 1'b1) begin n_bad++; $display("FAIL single_accept got %b want 1", s_acc); end
    bus.in_valid = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (t <= 10) begin
        n_cmp++; if (s_rdy !== 1'b0) begin n_bad++; $display("FAIL single_in_ready t=%0d got %b want 0", t, s_rdy); end
        n_cmp++; if (s_sel !== 4'(order(t-1))) begin n_bad++; $display("FAIL single_mux_s t=%0d got %0d want %0d", t, s_sel, order(t-1)); end
      end else begin
        n_cmp++; if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL single_ready_after got %b want 1", s_rdy); end
      end
      if (t == 1) begin
        n_cmp++; if (s_vld !== 1'b0) begin n_bad++; $display("FAIL single_first_valid got %b want 0", s_vld); end
      end else begin
        n_cmp++;
        if (s_vld !== 1'b1 || !e_ok || s_data !== e.d || s_last !== e.l) begin
          n_bad++; $display("FAIL single_bit t=%0d got v=%b d=%b l=%b want v=1 d=%b l=%b", t, s_vld, s_data, s_last, e.d, e.l);
        end
      end
    end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL single_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int nfired = 0;
    logic prev_stall = 1'b0;
    logic [3:0] prev_sel = '0;
    bus.ser_ready = pat[0]; bus.in_valid = 1'b1; bus.in_data = 10'h3C5;
    tick();
    bus.in_valid = 1'b0;
    for (int cyc = 1; cyc < 80 && (q.size() != 0 || cyc == 1); cyc++) begin
      bus.ser_ready = pat[cyc % 4];
      tick();
      if (!s_rdy) begin
        n_cmp++; if (s_sel !== 4'(order(nfired + int'(s_vld)))) begin n_bad++; $display("FAIL bp_mux_s cyc=%0d got %0d want %0d", cyc, s_sel, order(nfired + int'(s_vld))); end
      end
      if (prev_stall) begin
        n_cmp++; if (s_sel !== prev_sel) begin n_bad++; $display("FAIL bp_stall_freeze cyc=%0d got %0d want %0d", cyc, s_sel, prev_sel); end
      end
      prev_stall = s_vld && !s_sready && !s_rdy;
      prev_sel = s_sel;
      if (s_fire) begin
        nfired++;
        n_cmp++; if (!e_ok || s_data !== e.d || s_last !== e.l) begin n_bad++; $display("FAIL bp_bit n=%0d got d=%b l=%b want d=%b l=%b", nfired, s_data, s_last, e.d, e.l); end
      end
    end
    bus.ser_ready = 1'b1;
    n_cmp++; if (nfired != 10) begin n_bad++; $display("FAIL bp_count got %0d want 10", nfired); end
  endtask

  task automatic test_back_to_back();
    int acc_t[$];
    int nfired = 0;
    int nlast = 0;
    bus.ser_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 10'h155;
    for (int cyc = 0; cyc < 40 && !(acc_t.size() == 2 && q.size() == 0); cyc++) begin
      tick();
      if (s_acc) begin
        acc_t.push_back(cyc);
        if (acc_t.size() == 1) bus.in_data = 10'h2AA; else bus.in_valid = 1'b0;
      end
      if (s_fire) begin
        nfired++;
        n_cmp++; if (!e_ok || s_data !== e.d || s_last !== e.l) begin n_bad++; $display("FAIL b2b_bit n=%0d got d=%b l=%b want d=%b l=%b", nfired, s_data, s_last, e.d, e.l); end
        if (s_last) nlast++;
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (acc_t.size() != 2) begin n_bad++; $display("FAIL b2b_accepts got %0d want 2", acc_t.size()); end
    else begin
      n_cmp++; if (acc_t[1] - acc_t[0] != 11) begin n_bad++; $display("FAIL b2b_spacing got %0d want 11", acc_t[1] - acc_t[0]); end
    end
    n_cmp++; if (nfired != 20) begin n_bad++; $display("FAIL b2b_count got %0d want 20", nfired); end
    n_cmp++; if (nlast != 2) begin n_bad++; $display("FAIL b2b_lasts got %0d want 2", nlast); end
  endtask

  task automatic test_reset_mid();
    int nfired = 0;
    logic any_vld = 1'b0;
    logic any_last = 1'b0;
    bus.ser_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 10'h2B6;
    tick();
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && nfired < 4; cyc++) begin
      tick();
      if (s_fire) begin
        nfired++;
        n_cmp++; if (!e_ok || s_data !== e.d || s_last !== e.l) begin n_bad++; $display("FAIL rmid_bit n=%0d got d=%b l=%b want d=%b l=%b", nfired, s_data, s_last, e.d, e.l); end
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    tick();
    n_cmp++; if (s_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_ser_valid got %b want 0", s_vld); end
    n_cmp++; if (s_sel !== 4'd0) begin n_bad++; $display("FAIL rmid_mux_s got %0d want 0", s_sel); end
    n_cmp++; if (s_mi !== 16'd0) begin n_bad++; $display("FAIL rmid_mux_i got %h want 0", s_mi); end
    n_cmp++; if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready got %b want 1", s_rdy); end
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      any_vld |= s_vld; any_last |= s_last;
    end
    n_cmp++; if (any_vld !== 1'b0 || any_last !== 1'b0) begin n_bad++; $display("FAIL rmid_quiet got valid=%b last=%b want 0/0", any_vld, any_last); end
  endtask

  task automatic test_ignore();
    logic [9:0] word = 10'h0A3;
    int nfired = 0;
    bus.ser_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = word;
    tick();
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 30 && nfired < 10; cyc++) begin
      if (cyc == 3) begin bus.in_valid = 1'b1; bus.in_data = 10'h3FF; end
      else if (cyc == 4) begin bus.in_valid = 1'b0; bus.in_data = word; end
      tick();
      n_cmp++; if (s_acc !== 1'b0) begin n_bad++; $display("FAIL ign_accept cyc=%0d got %b want 0", cyc, s_acc); end
      n_cmp++; if (s_mi !== {6'b0, word}) begin n_bad++; $display("FAIL ign_mux_i cyc=%0d got %h want %h", cyc, s_mi, {6'b0, word}); end
      if (s_fire) begin
        nfired++;
        n_cmp++; if (!e_ok || s_data !== e.d || s_last !== e.l) begin n_bad++; $display("FAIL ign_bit n=%0d got d=%b l=%b want d=%b l=%b", nfired, s_data, s_last, e.d, e.l); end
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (nfired != 10 || q.size() != 0) begin n_bad++; $display("FAIL ign_count got %0d/%0d left want 10/0", nfired, q.size()); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.ser_ready = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
